// File: rtl/alu_li_requester.sv
// alu_li_requester: host-side initiator for the latency-insensitive ALU.
// Commands pass through a one-entry issue register to the ALU input channel.
// Results come back in order through a one-entry response register, tagged
// with a wrapping sequence number. At most MAX_OUTSTANDING operations are in
// flight at once.
//
// Valid/ready contract on every channel: a transfer happens in any cycle where
// valid && ready; once this block raises alu_valid or rsp_valid it keeps the
// valid and its payload stable until that transfer happens.
//
// Optional feature: define ALU_LI_REQ_TIMEOUT_EN to build a result-wait
// watchdog that sets timeout_err after TIMEOUT_CYCLES cycles without a result
// while operations are in flight. Without it, timeout_err flags only a result
// that arrives with nothing outstanding.
module alu_li_requester #(
    parameter int WIDTH           = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SEQ_W           = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic             clk,
    input  logic             reset,
    // host command stream
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_op,
    // ALU input channel
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op,
    output logic             alu_valid,
    input  logic             alu_ready,
    // ALU output channel
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_result_valid,
    output logic             alu_result_ready,
    // host response stream
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [SEQ_W-1:0] rsp_seq,
    // status
    output logic [3:0]       outstanding,
    output logic             timeout_err,
    output logic [1:0]       dbg_state_o
);

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             iss_full_q, iss_full_d;
    logic [WIDTH-1:0] iss_a_q, iss_a_d;
    logic [WIDTH-1:0] iss_b_q, iss_b_d;
    logic             iss_op_q, iss_op_d;
    logic             held_q, held_d;
    logic [3:0]       out_q, out_d;
    logic             rsp_full_q, rsp_full_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [SEQ_W-1:0] rsp_seq_q, rsp_seq_d;
    logic [SEQ_W-1:0] done_cnt_q, done_cnt_d;
    logic             err_q, err_d;

    logic alu_valid_c, alu_fire, cmd_ready_c, cmd_fire;
    logic res_ready_c, res_fire, res_accept, res_unexp, rsp_fire;
    logic timeout_hit;

    // Handshake decode: a held request always stays up; a new one is raised
    // only below the in-flight limit and never while in ERROR.
    always_comb begin
        alu_valid_c = iss_full_q &&
                      (held_q || ((state_q != ST_ERROR) && (out_q < MAX_OUT)));
        alu_fire    = alu_valid_c && alu_ready;
        cmd_ready_c = reset && (!iss_full_q || alu_fire);
        cmd_fire    = cmd_valid && cmd_ready_c;
        rsp_fire    = rsp_full_q && rsp_ready;
        res_ready_c = reset && (!rsp_full_q || rsp_fire);
        res_fire    = alu_result_valid && res_ready_c;
        res_accept  = res_fire && (out_q != 4'd0);
        res_unexp   = res_fire && (out_q == 4'd0);
    end

`ifdef ALU_LI_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Result-wait watchdog: counts idle-result cycles while work is in flight.
    always_comb begin
        tmo_d = tmo_q;
        if ((out_q == 4'd0) || res_fire) begin
            tmo_d = '0;
        end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + TW'(1);
        end
        timeout_hit = (tmo_d == TW'(TIMEOUT_CYCLES));
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Datapath next state: issue register, in-flight count, response register.
    always_comb begin
        iss_full_d   = iss_full_q;
        iss_a_d      = iss_a_q;
        iss_b_d      = iss_b_q;
        iss_op_d     = iss_op_q;
        out_d        = out_q;
        rsp_full_d   = rsp_full_q;
        rsp_result_d = rsp_result_q;
        rsp_seq_d    = rsp_seq_q;
        done_cnt_d   = done_cnt_q;
        held_d       = alu_valid_c && !alu_ready;
        err_d        = err_q || res_unexp || timeout_hit;

        if (cmd_fire) begin
            iss_full_d = 1'b1;
            iss_a_d    = cmd_a;
            iss_b_d    = cmd_b;
            iss_op_d   = cmd_op;
        end else if (alu_fire) begin
            iss_full_d = 1'b0;
        end

        if (alu_fire && !res_accept) begin
            out_d = out_q + 4'd1;
        end else if (!alu_fire && res_accept) begin
            out_d = out_q - 4'd1;
        end

        if (res_accept) begin
            rsp_full_d   = 1'b1;
            rsp_result_d = alu_result;
            rsp_seq_d    = done_cnt_q;
            done_cnt_d   = done_cnt_q + SEQ_W'(1);
        end else if (rsp_fire) begin
            rsp_full_d = 1'b0;
        end
    end

    // FSM next state from the next-cycle counts; ERROR is terminal until reset.
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_ERROR) || err_d) begin
            state_d = ST_ERROR;
        end else if (out_d == MAX_OUT) begin
            state_d = ST_STALL;
        end else if ((out_d == 4'd0) && !iss_full_d) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_ACTIVE;
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            iss_full_q   <= 1'b0;
            iss_a_q      <= '0;
            iss_b_q      <= '0;
            iss_op_q     <= 1'b0;
            held_q       <= 1'b0;
            out_q        <= 4'd0;
            rsp_full_q   <= 1'b0;
            rsp_result_q <= '0;
            rsp_seq_q    <= '0;
            done_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            iss_full_q   <= iss_full_d;
            iss_a_q      <= iss_a_d;
            iss_b_q      <= iss_b_d;
            iss_op_q     <= iss_op_d;
            held_q       <= held_d;
            out_q        <= out_d;
            rsp_full_q   <= rsp_full_d;
            rsp_result_q <= rsp_result_d;
            rsp_seq_q    <= rsp_seq_d;
            done_cnt_q   <= done_cnt_d;
            err_q        <= err_d;
        end
    end

    assign cmd_ready        = cmd_ready_c;
    assign alu_a            = iss_a_q;
    assign alu_b            = iss_b_q;
    assign alu_op           = iss_op_q;
    assign alu_valid        = alu_valid_c;
    assign alu_result_ready = res_ready_c;
    assign rsp_valid        = rsp_full_q;
    assign rsp_result       = rsp_result_q;
    assign rsp_seq          = rsp_seq_q;
    assign outstanding      = out_q;
    assign timeout_err      = err_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_alu_li_requester.sv
// tb_alu_li_requester: drives alu_li_requester against a behavioural ALU stub
// (integer add/mul, fixed per-op latency, in-order return) and checks the
// response stream against an expected queue filled at command acceptance.
module tb_alu_li_requester;

    localparam int W       = 32;
    localparam int MAX     = 4;
    localparam int SW      = 8;
    localparam int TMO     = 64;
    localparam int ADD_LAT = 1;
    localparam int MUL_LAT = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_b = '0;
    logic          cmd_op = 1'b0;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic          alu_op;
    logic          alu_valid;
    logic          alu_ready = 1'b0;
    logic [W-1:0]  alu_result = '0;
    logic          alu_result_valid = 1'b0;
    logic          alu_result_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic [SW-1:0] rsp_seq;
    logic [3:0]    outstanding;
    logic          timeout_err;
    logic [1:0]    dbg_state;

    alu_li_requester #(
        .WIDTH(W), .MAX_OUTSTANDING(MAX), .SEQ_W(SW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_result(alu_result), .alu_result_valid(alu_result_valid),
        .alu_result_ready(alu_result_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_seq(rsp_seq),
        .outstanding(outstanding), .timeout_err(timeout_err),
        .dbg_state_o(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // bench state
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0]  exp_q[$];
    logic [SW-1:0] exp_seq;
    int            rsp_count;
    logic [W-1:0]  alu_q[$];
    int            alu_t[$];
    int            model_out;

    bit           cmd_pending;
    logic [W-1:0] pa, pb;
    logic         pop;
    int           alu_rdy_pct = 100;
    int           rsp_rdy_pct = 100;
    bit           hold_results, inject_res;

    bit           prev_alu_hold, prev_rsp_hold;
    logic [W-1:0] prev_a, prev_b, prev_rr;
    logic         prev_op;
    logic [SW-1:0] prev_rs;

    int last_cmd_step, last_alu_step, first_rsp_step;
    int first_fire_step, last_fire_step;

    // driver: one clock cycle. Inputs change on the falling edge; the
    // transfers that the next rising edge performs are recorded #1 later.
    task automatic step();
        bit cf, af, rf, pf;
        int mo;
        logic [W-1:0] e;
        @(negedge clk);
        cyc++;
        alu_ready = ($urandom_range(1, 100) <= alu_rdy_pct);
        rsp_ready = ($urandom_range(1, 100) <= rsp_rdy_pct);
        if (inject_res) begin
            alu_result_valid = 1'b1;
            alu_result       = $urandom;
        end else if (!hold_results && alu_q.size() > 0 && alu_t[0] <= cyc) begin
            alu_result_valid = 1'b1;
            alu_result       = alu_q[0];
        end else begin
            alu_result_valid = 1'b0;
            alu_result       = '0;
        end
        cmd_valid = cmd_pending;
        cmd_a     = pa;
        cmd_b     = pb;
        cmd_op    = pop;
        #1;
        total++;
        if (outstanding !== 4'(model_out)) begin
            bad++;
            $display("FAIL outstanding_count: got %0d want %0d (cycle %0d)", outstanding, model_out, cyc);
        end
        if (prev_alu_hold) begin
            total++;
            if (alu_valid !== 1'b1 || alu_a !== prev_a || alu_b !== prev_b || alu_op !== prev_op) begin
                bad++;
                $display("FAIL alu_hold: valid=%b a=%h b=%h op=%b want valid=1 a=%h b=%h op=%b",
                         alu_valid, alu_a, alu_b, alu_op, prev_a, prev_b, prev_op);
            end
        end
        if (prev_rsp_hold) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_result !== prev_rr || rsp_seq !== prev_rs) begin
                bad++;
                $display("FAIL rsp_hold: valid=%b result=%h seq=%0d want valid=1 result=%h seq=%0d",
                         rsp_valid, rsp_result, rsp_seq, prev_rr, prev_rs);
            end
        end
        if (rsp_valid && first_rsp_step < 0) first_rsp_step = cyc;

        cf = cmd_valid && cmd_ready;
        af = alu_valid && alu_ready;
        rf = alu_result_valid && alu_result_ready;
        pf = rsp_valid && rsp_ready;

        if (cf) begin
            e = pop ? pa * pb : pa + pb;
            exp_q.push_back(e);
            cmd_pending   = 1'b0;
            last_cmd_step = cyc;
        end
        if (af) begin
            e = alu_op ? alu_a * alu_b : alu_a + alu_b;
            alu_q.push_back(e);
            alu_t.push_back(cyc + (alu_op ? MUL_LAT : ADD_LAT));
            last_alu_step = cyc;
        end
        mo = model_out;
        if (af) model_out++;
        if (rf) begin
            if (!inject_res && alu_q.size() > 0) begin
                void'(alu_q.pop_front());
                void'(alu_t.pop_front());
            end
            if (mo > 0) model_out--;
        end
        if (pf) begin
            total++;
            if (first_fire_step < 0) first_fire_step = cyc;
            last_fire_step = cyc;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: result=%h seq=%0d with nothing expected", rsp_result, rsp_seq);
            end else begin
                e = exp_q.pop_front();
                if (rsp_result !== e || rsp_seq !== exp_seq) begin
                    bad++;
                    $display("FAIL rsp_data: result=%h seq=%0d want result=%h seq=%0d",
                             rsp_result, rsp_seq, e, exp_seq);
                end
            end
            exp_seq++;
            rsp_count++;
        end

        prev_alu_hold = alu_valid && !alu_ready;
        prev_a = alu_a; prev_b = alu_b; prev_op = alu_op;
        prev_rsp_hold = rsp_valid && !rsp_ready;
        prev_rr = rsp_result; prev_rs = rsp_seq;
    endtask

    // driver: hold reset low for n cycles and clear the bench model
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        cmd_valid = 1'b0; alu_ready = 1'b0; alu_result_valid = 1'b0; rsp_ready = 1'b0;
        cmd_pending = 1'b0; inject_res = 1'b0; hold_results = 1'b0;
        exp_q.delete(); alu_q.delete(); alu_t.delete();
        exp_seq = '0; rsp_count = 0; model_out = 0;
        prev_alu_hold = 1'b0; prev_rsp_hold = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic load_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        pa = a; pb = b; pop = op; cmd_pending = 1'b1;
    endtask

    // driver: step until all commands accepted and all responses returned
    task automatic drain(input int budget, output bit ok);
        int n = 0;
        while ((cmd_pending || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        ok = !(cmd_pending || exp_q.size() > 0);
    endtask

    // driver: push n random commands (op mix given) and wait for all responses
    task automatic run_traffic(input int n, input bit any_op, input int budget, output bit ok);
        int sent = 0;
        int used = 0;
        while ((sent < n || cmd_pending || exp_q.size() > 0) && used < budget) begin
            if (!cmd_pending && sent < n) begin
                load_cmd($urandom, $urandom, any_op ? 1'($urandom_range(0, 1)) : 1'b0);
                sent++;
            end
            step();
            used++;
        end
        ok = (sent == n) && !cmd_pending && exp_q.size() == 0;
    endtask

    task automatic test_reset();
        do_reset(3);
        total++;
        if (cmd_ready !== 1'b0 || alu_valid !== 1'b0 || alu_result_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake: cmd_ready=%b alu_valid=%b alu_result_ready=%b rsp_valid=%b want all 0",
                     cmd_ready, alu_valid, alu_result_ready, rsp_valid);
        end
        total++;
        if (alu_a !== '0 || alu_b !== '0 || alu_op !== 1'b0 || rsp_result !== '0 || rsp_seq !== '0) begin
            bad++;
            $display("FAIL reset_payload: alu_a=%h alu_b=%h alu_op=%b rsp_result=%h rsp_seq=%h want all 0",
                     alu_a, alu_b, alu_op, rsp_result, rsp_seq);
        end
        total++;
        if (outstanding !== 4'd0 || timeout_err !== 1'b0 || dbg_state !== S_IDLE) begin
            bad++;
            $display("FAIL reset_status: outstanding=%0d timeout_err=%b state=%0d want 0 0 IDLE",
                     outstanding, timeout_err, dbg_state);
        end
        release_reset();
        total++;
        if (cmd_ready !== 1'b1 || alu_result_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: cmd_ready=%b alu_result_ready=%b want 1 1", cmd_ready, alu_result_ready);
        end
    endtask

    task automatic test_single(input logic op, input int lat);
        bit ok;
        alu_rdy_pct = 100; rsp_rdy_pct = 100;
        first_rsp_step = -1;
        load_cmd(32'h4000_0000, 32'h4040_0000, op);
        drain(40, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_op%0d_done: response not returned within budget", op);
        end
        total++;
        if (first_rsp_step - last_cmd_step !== 2 + lat) begin
            bad++;
            $display("FAIL single_op%0d_latency: got %0d cycles want %0d", op, first_rsp_step - last_cmd_step, 2 + lat);
        end
        step();
        total++;
        if (outstanding !== 4'd0 || dbg_state !== S_IDLE) begin
            bad++;
            $display("FAIL single_op%0d_idle: outstanding=%0d state=%0d want 0 IDLE", op, outstanding, dbg_state);
        end
    endtask

    task automatic test_limit();
        bit ok;
        int n;
        do_reset(2);
        release_reset();
        alu_rdy_pct = 100; rsp_rdy_pct = 0;
        for (int i = 0; i < 6; i++) begin
            load_cmd($urandom, $urandom, 1'($urandom_range(0, 1)));
            n = 0;
            while (cmd_pending && n < 30) begin
                step();
                n++;
            end
        end
        repeat (10) step();
        total++;
        if (cmd_pending) begin
            bad++;
            $display("FAIL limit_accept: sixth command never accepted");
        end
        total++;
        if (outstanding !== 4'(MAX) || alu_valid !== 1'b0 || dbg_state !== S_STALL || rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL limit_stall: outstanding=%0d alu_valid=%b state=%0d rsp_valid=%b want %0d 0 STALL 1",
                     outstanding, alu_valid, dbg_state, rsp_valid, MAX);
        end
        rsp_rdy_pct = 100;
        drain(60, ok);
        total++;
        if (!ok || rsp_count != 6) begin
            bad++;
            $display("FAIL limit_drain: got %0d responses want 6", rsp_count);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset(2);
        release_reset();
        alu_rdy_pct = 100; rsp_rdy_pct = 100;
        first_fire_step = -1;
        run_traffic(20, 1'b0, 200, ok);
        total++;
        if (!ok || last_fire_step - first_fire_step != 19) begin
            bad++;
            $display("FAIL back_to_back: ok=%b response span %0d cycles want 19", ok, last_fire_step - first_fire_step);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset(2);
        release_reset();
        alu_rdy_pct = 70; rsp_rdy_pct = 70;
        run_traffic(258, 1'b1, 5000, ok);
        total++;
        if (!ok || rsp_count != 258 || exp_seq !== 8'd2) begin
            bad++;
            $display("FAIL wrap: ok=%b responses=%0d next_seq=%0d want 258 responses next_seq=2", ok, rsp_count, exp_seq);
        end
        alu_rdy_pct = 100; rsp_rdy_pct = 100;
    endtask

    task automatic test_unexpected_result();
        int n;
        bit raised;
        do_reset(2);
        release_reset();
        inject_res = 1'b1;
        step();
        inject_res = 1'b0;
        step();
        total++;
        if (timeout_err !== 1'b1 || outstanding !== 4'd0 || rsp_valid !== 1'b0 || dbg_state !== S_ERROR) begin
            bad++;
            $display("FAIL unexpected_result: timeout_err=%b outstanding=%0d rsp_valid=%b state=%0d want 1 0 0 ERROR",
                     timeout_err, outstanding, rsp_valid, dbg_state);
        end
        load_cmd($urandom, $urandom, 1'b0);
        n = 0;
        while (cmd_pending && n < 5) begin
            step();
            n++;
        end
        raised = 1'b0;
        repeat (8) begin
            step();
            if (alu_valid) raised = 1'b1;
        end
        total++;
        if (cmd_pending || raised) begin
            bad++;
            $display("FAIL error_no_issue: cmd_still_pending=%b alu_valid_seen=%b want 0 0", cmd_pending, raised);
        end
        do_reset(2);
        total++;
        if (timeout_err !== 1'b0 || alu_valid !== 1'b0 || cmd_ready !== 1'b0 || dbg_state !== S_IDLE) begin
            bad++;
            $display("FAIL error_reset: timeout_err=%b alu_valid=%b cmd_ready=%b state=%0d want 0 0 0 IDLE",
                     timeout_err, alu_valid, cmd_ready, dbg_state);
        end
        release_reset();
    endtask

`ifdef ALU_LI_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit raised;
        do_reset(2);
        release_reset();
        alu_rdy_pct = 100; rsp_rdy_pct = 100;
        hold_results = 1'b1;
        last_alu_step = -1;
        load_cmd($urandom, $urandom, 1'b0);
        n = 0;
        while (last_alu_step < 0 && n < 10) begin
            step();
            n++;
        end
        n = 0;
        while (timeout_err !== 1'b1 && n < 4 * TMO) begin
            step();
            n++;
        end
        total++;
        if (timeout_err !== 1'b1 || cyc - last_alu_step != TMO + 1) begin
            bad++;
            $display("FAIL timeout_delay: timeout_err=%b after %0d cycles want 1 after %0d",
                     timeout_err, cyc - last_alu_step, TMO + 1);
        end
        load_cmd($urandom, $urandom, 1'b1);
        raised = 1'b0;
        repeat (8) begin
            step();
            if (alu_valid) raised = 1'b1;
        end
        total++;
        if (raised) begin
            bad++;
            $display("FAIL timeout_no_issue: alu_valid seen=%b want 0", raised);
        end
        do_reset(2);
        total++;
        if (timeout_err !== 1'b0 || outstanding !== 4'd0 || alu_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_reset: timeout_err=%b outstanding=%0d alu_valid=%b rsp_valid=%b want all 0",
                     timeout_err, outstanding, alu_valid, rsp_valid);
        end
        release_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single(1'b0, ADD_LAT);
        test_single(1'b1, MUL_LAT);
        test_limit();
        test_back_to_back();
        test_wrap();
        test_unexpected_result();
`ifdef ALU_LI_REQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
